// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared types and helpers for the serial arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Sequencer states of the bit-serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sub_state_t;

    // Width of a bit counter that must reach WIDTH-1
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_fsub.sv
`default_nettype none
// ============================================================================
//  Module      : fsub
//  Description : Combinational 1-bit full subtractor (a - b - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
module fsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    // Difference bit and borrow generation
    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Bit-serial subtractor, num1 - num2, LSB first through one
//                full-subtractor cell; result after WIDTH+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] out,
    output logic             bout
);

    localparam int         CNT_W     = cnt_w(WIDTH);
    localparam logic [1:0] c_st_idle = 2'(IDLE);
    localparam logic [1:0] c_st_run  = 2'(RUN);
    localparam logic [1:0] c_st_fin  = 2'(FIN);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_done;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_bout;

    logic             w_d;
    logic             w_bo;

    // Single subtractor cell, fed the current LSBs and the running borrow
    fsub u_fsub (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bo)
    );

    // Sequencer: capture operands, shift one bit per cycle, publish result.
    // New requests are taken only from IDLE so that a held start yields one
    // operation every WIDTH+2 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a      <= num1;
                        r_b      <= num2;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_valid  <= 1'b0;
                        r_state  <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bo;
                    if (r_cnt == c_last) begin
                        r_state <= c_st_fin;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_st_fin: begin
                    r_out   <= r_res;
                    r_bout  <= r_borrow;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy  = (r_state == c_st_run);
    assign done  = r_done;
    assign valid = r_valid;
    assign out   = r_out;
    assign bout  = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub
//  Description : Self-checking bench for serial_sub with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << (WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] out;
    logic             bout;

    int n_tests;
    int n_fail;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .num1  (num1),
        .num2  (num2),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .out   (out),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout,out} = (num1 - num2) mod 2^(WIDTH+1)
    function automatic logic [WIDTH:0] ref_sub(input int a, input int b);
        int r;
        r = (a - b + MOD) % MOD;
        return r[WIDTH:0];
    endfunction

    // Issue one operation and wait (bounded) for its done pulse
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [WIDTH:0] res, output bit timeout);
        @(negedge clk);
        num1 = a; num2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num1 = WIDTH'($urandom); num2 = WIDTH'($urandom);
        lat = 0; busy_cnt = 0; timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
        res = {bout, out};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, valid, bout, out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b bout=%b out=%h, want all 0",
                     busy, done, valid, bout, out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc; logic [WIDTH:0] res; bit to;
        do_op(4'd9, 4'd5, lat, bc, res, to);
        n_tests++;
        if (to || lat != WIDTH + 1 || bc != WIDTH) begin
            n_fail++;
            $display("FAIL basic_timing: got lat=%0d busy=%0d timeout=%0b, want lat=%0d busy=%0d",
                     lat, bc, to, WIDTH + 1, WIDTH);
        end
        n_tests++;
        if (res !== 5'h04 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_9m5: got bout/out=%h valid=%b, want 04 valid=1", res, valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0 || valid !== 1'b1 || out !== 4'd4) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b valid=%b out=%h, want done=0 valid=1 out=4",
                     done, valid, out);
        end
    endtask

    task automatic test_corners();
        logic [WIDTH-1:0] ta [4] = '{4'd2, 4'd0, 4'd15, 4'd0};
        logic [WIDTH-1:0] tb [4] = '{4'd3, 4'd0, 4'd15, 4'd15};
        logic [WIDTH:0]   te [4] = '{5'h1F, 5'h00, 5'h00, 5'h11};
        int lat, bc; logic [WIDTH:0] res; bit to;
        for (int k = 0; k < 4; k++) begin
            do_op(ta[k], tb[k], lat, bc, res, to);
            n_tests++;
            if (to || res !== te[k]) begin
                n_fail++;
                $display("FAIL corner_%0d-%0d: got bout/out=%h timeout=%0b, want %h",
                         ta[k], tb[k], res, to, te[k]);
            end
        end
    endtask

    // New start issued in the done cycle is taken; old result is held meanwhile
    task automatic test_start_on_done();
        int lat, bc; logic [WIDTH:0] res; bit to;
        do_op(4'd9, 4'd5, lat, bc, res, to);
        num1 = 4'd2; num2 = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || busy !== 1'b1 || out !== 4'd4 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL start_on_done: got valid=%b busy=%b out=%h bout=%b, want 0 1 4 0",
                     valid, busy, out, bout);
        end
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin to = 1'b0; break; end
        end
        n_tests++;
        if (to || {bout, out} !== 5'h1F) begin
            n_fail++;
            $display("FAIL start_on_done_result: got %h timeout=%0b, want 1f", {bout, out}, to);
        end
    endtask

    task automatic test_back_to_back();
        int d_cyc [$];
        int cyc;
        bit bad;
        bad = 1'b0; cyc = 0;
        @(negedge clk);
        num1 = 4'd8; num2 = 4'd8; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                d_cyc.push_back(cyc);
                if ({bout, out} !== 5'h00) bad = 1'b1;
            end
            if (busy) begin
                num1 = WIDTH'($urandom); num2 = WIDTH'($urandom);
            end else begin
                num1 = 4'd8; num2 = 4'd8;
            end
        end
        start = 1'b0;
        n_tests++;
        if (d_cyc.size() < 2 || bad) begin
            n_fail++;
            $display("FAIL b2b_results: got %0d done pulses bad_value=%0b, want >=2 all zero",
                     d_cyc.size(), bad);
        end else begin
            n_tests++;
            if (d_cyc[1] - d_cyc[0] != WIDTH + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles, want %0d", d_cyc[1] - d_cyc[0], WIDTH + 2);
            end
        end
        repeat (WIDTH + 4) @(posedge clk);
    endtask

    task automatic test_ignore_start();
        bit to, extra;
        int lat;
        @(negedge clk);
        num1 = 4'd9; num2 = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        num1 = 4'd1; num2 = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        to = 1'b1; lat = 2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin to = 1'b0; break; end
        end
        n_tests++;
        if (to || lat != WIDTH + 1 || {bout, out} !== 5'h04) begin
            n_fail++;
            $display("FAIL ignore_start: got %h lat=%0d timeout=%0b, want 04 lat=%0d",
                     {bout, out}, lat, to, WIDTH + 1);
        end
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (busy || done) extra = 1'b1;
        end
        n_tests++;
        if (extra) begin
            n_fail++;
            $display("FAIL ignore_start_queued: got activity after done=1, want 0");
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        int lat, bc; logic [WIDTH:0] res; bit to;
        @(negedge clk);
        num1 = 4'd12; num2 = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, valid, bout, out} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b bout=%b out=%h, want all 0",
                     busy, done, valid, bout, out);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL async_reset_no_done: got activity=1, want 0");
        end
        do_op(4'd7, 4'd2, lat, bc, res, to);
        n_tests++;
        if (to || res !== 5'h05) begin
            n_fail++;
            $display("FAIL after_reset_7m2: got %h timeout=%0b, want 05", res, to);
        end
    endtask

    task automatic test_random();
        int lat, bc; logic [WIDTH:0] res, exp_v; bit to;
        logic [WIDTH-1:0] a, b;
        for (int k = 0; k < 40; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            exp_v = ref_sub(int'(a), int'(b));
            do_op(a, b, lat, bc, res, to);
            n_tests++;
            if (to || res !== exp_v || lat != WIDTH + 1) begin
                n_fail++;
                $display("FAIL random_%0d-%0d: got %h lat=%0d, want %h lat=%0d",
                         a, b, res, lat, exp_v, WIDTH + 1);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, bc; logic [WIDTH:0] res, exp_v; bit to;
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                exp_v = ref_sub(a, b);
                do_op(WIDTH'(a), WIDTH'(b), lat, bc, res, to);
                n_tests++;
                if (to || res !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep_%0d-%0d: got %h, want %h ERRO", a, b, res, exp_v);
                end else begin
                    $display("OK %0d-%0d = %h", a, b, res);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_corners();
        test_start_on_done();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        test_random();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
